oam_dma: RTL
============

// Module: oam_dma
// PURPOSE
// - OAM DMA controller and bus owner between cpu and the shared memory bus (bootrom/cart/wram/hram/ppu mux).
// - A CPU write to FF46 with value S copies the 160 bytes at {S',8'h00}..{S',8'h9F} into FE00..FE9F.
// - While the copy runs, this block drives the shared bus and locks the CPU out.
// - Otherwise it passes CPU accesses straight through, and it holds the FF46 register.
// PARAMETERS
// - READ_LATENCY  1    extra cycles the source address is held before mem_data_r is sampled (>=0)
// - DMA_LEN       160  bytes per transfer (8 bits, 1..255)
// - DMA_REG       16'hFF46  address of the DMA source register
// PORTS
// - clk           in   1   system clock
// - reset_n       in   1   reset; one clock, synchronous, active-low
// - cpu_addr      in   16  CPU address
// - cpu_data_w    in   8   CPU write data
// - cpu_do_write  in   1   CPU write strobe
// - cpu_data_r    out  8   read data returned to the CPU
// - mem_data_r    in   8   read data from the memory read mux
// - bus_addr      out  16  address to the memory devices
// - bus_data_w    out  8   write data to the memory devices
// - bus_do_write  out  1   write strobe to the memory devices
// - dma_active    out  1   high while a transfer is in progress
// BEHAVIOUR
// - Reset (reset_n low at posedge): state=IDLE, dma_src=8'h00, index=0, dma_active=0, latched byte=0.
// - Effective source high byte S' = S; if S>=8'hE0 then S' = S & 8'hDF (echo into WRAM).
// - IDLE, bus pass-through:
//   - bus_addr=cpu_addr, bus_data_w=cpu_data_w.
//   - bus_do_write=cpu_do_write, except when cpu_addr==DMA_REG.
//   - cpu_data_r=mem_data_r, except cpu_addr==DMA_REG returns dma_src.
// - FSM states: IDLE -> START (1 cycle) -> READ (READ_LATENCY+1 cycles) -> WRITE (1 cycle).
//   - After WRITE: READ again if index<DMA_LEN-1, else IDLE.
// - READ: bus_addr={S',index}, bus_do_write=0.
//   - mem_data_r is latched at the posedge that ends the last READ cycle.
// - WRITE: bus_addr=16'hFE00+index, bus_data_w=latched byte, bus_do_write=1; index increments at the ending edge.
// - Timing, write to DMA_REG accepted at edge E0:
//   - dma_active=1 from E0 (combinational on state!=IDLE).
//   - Per-byte period is READ_LATENCY+2 cycles.
//   - dma_active falls at edge E0+1+DMA_LEN*(READ_LATENCY+2). With defaults this is E0+481.
// - CPU lockout while dma_active:
//   - cpu_data_r=8'hFF for every address except DMA_REG, which returns dma_src.
//   - CPU writes to any address other than DMA_REG are dropped and never reach the bus.
//   - HRAM is also locked out.
// - Restart: a write to DMA_REG while active loads the new dma_src and clears index.
//   - The FSM goes to START on the next edge; the byte in flight is abandoned and no partial write is issued.
// - A write to DMA_REG in the same cycle as the final WRITE: the final byte is still written, then START.
// - reset_n low mid-transfer aborts immediately; no further bus_do_write is issued.
// - index is 8 bits and never wraps; the destination never leaves FE00..FE00+DMA_LEN-1.
// CONFIGURATION
// - OAM_DMA_DBG_EN defined: adds output dbg_dma_index[7:0] (current index, 0 in IDLE).
// - Also adds output dbg_dma_count[15:0]: completed transfers, saturating at 16'hFFFF, reset to 0, not incremented on restart.
// - OAM_DMA_DBG_EN undefined: neither port nor counter exists; behaviour is otherwise identical.
// TESTING
// - Reset then idle: CPU read C123 -> bus_addr=C123 and cpu_data_r=mem_data_r; read FF46 -> 8'h00; dma_active=0.
// - Fill C000..C09F with i^8'h5A, write FF46=8'hC0:
//   - OAM FE00..FE9F = i^8'h5A; dma_active high exactly 481 cycles; 160 bus_do_write pulses.
// - During DMA: CPU read C000 -> 8'hFF; CPU write C010=8'h77 -> dropped, C010 unchanged.
// - During DMA: read FF46 -> 8'hC0.
// - Write FF46=8'hC0, then FF46=8'hD0 at cycle 100:
//   - FE00..FE9F = D000..D09F contents; dma_active falls 481 cycles after the second write.
// - Write FF46=8'hF1: the source read range is D100..D19F; FF46 reads back 8'hF1.
// - reset_n low at cycle 50 of a transfer -> next cycle dma_active=0, FF46=8'h00, no further writes to FE00..FE9F.

Source files
------------

// File: rtl/oam_dma.sv
// OAM DMA controller. It owns the shared memory bus while it copies a page into FE00..,
// and otherwise passes CPU accesses through. Define OAM_DMA_DBG_EN to add the debug index/count ports.
module oam_dma #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DMA_LEN      = 160,
    parameter logic [15:0] DMA_REG      = 16'hFF46
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_w,
    input  logic        cpu_do_write,
    output logic [7:0]  cpu_data_r,
    input  logic [7:0]  mem_data_r,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_w,
    output logic        bus_do_write,
`ifdef OAM_DMA_DBG_EN
    output logic [7:0]  dbg_dma_index,
    output logic [15:0] dbg_dma_count,
`endif
    output logic        dma_active
);

    localparam int unsigned LAT_W    = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);
    localparam logic [7:0]       IDX_LAST = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_READ,
        S_WRITE
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       src_q, src_d;
    logic [7:0]       index_q, index_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [7:0]       byte_q, byte_d;

    logic             reg_hit;
    logic             reg_write;
    logic [7:0]       src_eff;

    assign reg_hit    = (cpu_addr == DMA_REG);
    assign reg_write  = reg_hit && cpu_do_write;
    assign dma_active = (state_q != S_IDLE);

    // Pages E0..FF are the WRAM echo, so fold them back onto C0..DF.
    assign src_eff = (src_q >= 8'hE0) ? (src_q & 8'hDF) : src_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= 8'h00;
            index_q <= 8'h00;
            lat_q   <= '0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            index_q <= index_d;
            lat_q   <= lat_d;
            byte_q  <= byte_d;
        end
    end

    // NOTE: every signal driven here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        index_d = index_q;
        lat_d   = lat_q;
        byte_d  = byte_q;

        unique case (state_q)
            S_IDLE: begin
            end
            S_START: begin
                state_d = S_READ;
                lat_d   = '0;
            end
            S_READ: begin
                if (lat_q == LAT_LAST) begin
                    byte_d  = mem_data_r;
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_WRITE: begin
                lat_d = '0;
                if (index_q < IDX_LAST) begin
                    index_d = index_q + 8'd1;
                    state_d = S_READ;
                end else begin
                    index_d = 8'h00;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A register write always (re)starts; a byte mid-read is simply dropped.
        if (reg_write) begin
            src_d   = cpu_data_w;
            index_d = 8'h00;
            lat_d   = '0;
            state_d = S_START;
        end
    end

    always_comb begin
        bus_addr     = cpu_addr;
        bus_data_w   = cpu_data_w;
        bus_do_write = cpu_do_write && !reg_hit;
        cpu_data_r   = reg_hit ? src_q : mem_data_r;

        if (dma_active) begin
            cpu_data_r   = reg_hit ? src_q : 8'hFF;
            bus_addr     = {src_eff, index_q};
            bus_data_w   = byte_q;
            bus_do_write = 1'b0;
            if (state_q == S_WRITE) begin
                bus_addr     = 16'hFE00 + {8'h00, index_q};
                // Gated by reset so an aborting transfer never issues one more write.
                bus_do_write = reset_n;
            end
        end
    end

`ifdef OAM_DMA_DBG_EN
    logic [15:0] count_q, count_d;
    logic        last_write;

    assign last_write = (state_q == S_WRITE) && (index_q == IDX_LAST);

    always_comb begin
        count_d = count_q;
        if (last_write && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign dbg_dma_index = index_q;
    assign dbg_dma_count = count_q;
`endif

endmodule
